// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Purpose  : Shared state encoding and default width for the serial adder.
//  Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
//  Module   : fa_cell
//  Purpose  : Single-bit combinational full adder.
//  Revision : 1.0  initial release
// ============================================================================
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    logic w_prop;

    assign w_prop = x ^ y;
    assign s      = w_prop ^ z;
    assign c      = (x & y) | (w_prop & z);

endmodule : fa_cell
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial adder, one full-adder cell, LSB first, done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_step;
    logic               w_last;

    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [CNT_W-1:0]   r_count;

    logic               w_s;
    logic               w_c;

    fa_cell u_fa (
        .x (r_sh_a[0]),
        .y (r_sh_b[0]),
        .z (r_carry),
        .s (w_s),
        .c (w_c)
    );

    assign w_last = (r_count == C_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end
            end
            S_SHIFT: begin
                // start is deliberately not looked at here
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_count <= '0;
        end else if (w_load) begin
            r_sh_a  <= a;
            r_sh_b  <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_count <= '0;
        end else if (w_step) begin
            r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
            r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_c;
            // wrap at the last bit so the counter never passes WIDTH-1
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
            if (w_last) begin
                r_cout <= w_c;
            end
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Directed and random scoreboard bench for serial_adder (W=8, W=5).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start5, cin5, busy5, done5, cout5;
    logic [4:0] a5, b5, sum5;

    int n_assert;
    int n_fail;
    int cyc;
    int n_done8, n_done5;
    int last8, last5;
    bit space8_en, space5_en;

    logic [8:0] q8[$];
    logic [5:0] q5[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start5),
        .a     (a5),
        .b     (b5),
        .cin   (cin5),
        .busy  (busy5),
        .done  (done5),
        .sum   (sum5),
        .cout  (cout5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and score any done pulse against the queues.
    task automatic tick();
        logic [8:0] e8;
        logic [5:0] e5;
        @(posedge clk);
        #1;
        cyc++;
        if (!space8_en) last8 = -1;
        if (!space5_en) last5 = -1;
        if (done8 === 1'b1) begin
            n_done8++;
            if (q8.size() == 0) begin
                check("done8 unexpected", 32'(done8), 32'(0));
            end else begin
                e8 = q8.pop_front();
                check("result8", 32'({cout8, sum8}), 32'(e8));
            end
            if (space8_en && last8 >= 0) check("spacing8", 32'(cyc - last8), 32'(9));
            last8 = cyc;
        end
        if (done5 === 1'b1) begin
            n_done5++;
            if (q5.size() == 0) begin
                check("done5 unexpected", 32'(done5), 32'(0));
            end else begin
                e5 = q5.pop_front();
                check("result5", 32'({cout5, sum5}), 32'(e5));
            end
            if (space5_en && last5 >= 0) check("spacing5", 32'(cyc - last5), 32'(6));
            last5 = cyc;
        end
    endtask

    task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        q8.push_back({1'b0, ia} + {1'b0, ib} + {8'd0, ic});
        tick();
        start8 = 1'b0;
    endtask

    task automatic wait_done8();
        int k;
        k = 0;
        while (done8 !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("done8 wait", 32'(done8), 32'(1));
    endtask

    initial begin
        int d0;
        n_assert = 0; n_fail = 0; cyc = 0;
        n_done8 = 0; n_done5 = 0; last8 = -1; last5 = -1;
        space8_en = 1'b0; space5_en = 1'b0;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start5 = 1'b0; a5 = '0; b5 = '0; cin5 = 1'b0;

        // Reset state, then idle
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset5 outputs", 32'({busy5, done5, cout5, sum5}), 32'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle busy/done/cout/sum", 32'({busy8, done8, cout8, sum8}), 32'(0));
        end

        // FF + 01: busy 8 cycles, done on the 9th edge
        issue8(8'hFF, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("busy during shift", 32'(busy8), 32'(1));
            check("no early done", 32'(done8), 32'(0));
            tick();
        end
        check("done at edge 9", 32'(done8), 32'(1));
        check("busy low at done", 32'(busy8), 32'(0));
        tick();
        check("done one cycle", 32'(done8), 32'(0));
        check("sum held", 32'(sum8), 32'(8'h00));
        check("cout held", 32'(cout8), 32'(1));

        // Directed sums
        issue8(8'hA5, 8'h5A, 1'b1);
        wait_done8();
        tick();
        issue8(8'h12, 8'h34, 1'b0);
        wait_done8();
        tick();

        // start while busy is ignored
        d0 = n_done8;
        issue8(8'h0F, 8'h01, 1'b0);
        tick();
        tick();
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8();
        repeat (12) tick();
        check("done count busy-start", 32'(n_done8 - d0), 32'(1));

        // Reset mid-operation
        d0 = n_done8;
        issue8(8'h80, 8'h80, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("async reset busy", 32'(busy8), 32'(0));
        check("async reset done", 32'(done8), 32'(0));
        check("async reset sum", 32'(sum8), 32'(0));
        check("async reset cout", 32'(cout8), 32'(0));
        q8.delete();
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("no done after abort", 32'(n_done8 - d0), 32'(0));
        issue8(8'h80, 8'h80, 1'b0);
        wait_done8();
        tick();

        // Back-to-back random, WIDTH=8
        space8_en = 1'b1;
        start8 = 1'b1;
        d0 = n_done8;
        for (int n = 0; n < 200; n++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            q8.push_back({1'b0, a8} + {1'b0, b8} + {8'd0, cin8});
            repeat (9) tick();
        end
        start8 = 1'b0;
        repeat (3) tick();
        space8_en = 1'b0;
        check("random8 done count", 32'(n_done8 - d0), 32'(200));

        // Back-to-back random, WIDTH=5
        space5_en = 1'b1;
        start5 = 1'b1;
        d0 = n_done5;
        for (int n = 0; n < 200; n++) begin
            a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom);
            q5.push_back({1'b0, a5} + {1'b0, b5} + {5'd0, cin5});
            repeat (6) tick();
        end
        start5 = 1'b0;
        repeat (3) tick();
        space5_en = 1'b0;
        check("random5 done count", 32'(n_done5 - d0), 32'(200));

        check("queue8 drained", 32'(q8.size()), 32'(0));
        check("queue5 drained", 32'(q5.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
